// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants and fetch state encoding
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: small {pc,instr} buffer with push/pop/flush and occupancy count
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [2*XLEN-1:0]      din,
  output logic [2*XLEN-1:0]      dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing req/ack word fetches into a FIFO feeding decode;
// redirects flush buffered work and drop an unacked request once it returns.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, drop_addr_q, drop_addr_d;
  logic [CW-1:0] count, count_nxt;
  logic [2*XLEN-1:0] head;
  logic ack, push, pop, space;
  always_comb begin
    ack = imem_req & imem_ack;
    pop = inst_valid & inst_ready;
    push = (state_q == REQ) & ack & !redirect;
    count_nxt = count + CW'(push) - CW'(pop);
    space = count_nxt < CW'(DEPTH);
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect) begin
      // an unacked request cannot be withdrawn, so it is parked in DROP
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      state_d = (state_q != IDLE && !ack) ? DROP : REQ;
      if (state_q == REQ && !ack) drop_addr_d = fetch_pc_q;
    end else if (state_q == IDLE) begin
      state_d = space ? REQ : IDLE;
    end else if (ack) begin
      state_d = (state_q == DROP || space) ? REQ : IDLE;
      if (state_q == REQ) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end
  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din({fetch_pc_q, imem_rdata}),
    .dout(head),
    .count(count)
  );
  assign imem_req = state_q != IDLE;
  assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign inst_valid = count != '0;
  assign inst = inst_valid ? head[XLEN-1:0] : NOP_INSTR;
  assign inst_pc = inst_valid ? head[2*XLEN-1:XLEN] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory latency/ready/redirect against an ideal
// instruction-stream model, plus directed fetch scenarios.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, imem_ack = 0, redirect = 0, inst_ready = 0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  int n_chk = 0, n_fail = 0, n_acc = 0;
  int ack_pct = 100, slow_lat = 0, wait_cnt = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  typedef struct {logic [31:0] pc; logic [31:0] w;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] gen_pc;
  logic p_req = 0, p_ack = 0, p_val = 0, p_rdy = 0, p_redir = 0;
  logic [31:0] p_addr = 0, p_inst = 0, p_pc = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bounded wait expired, event not seen", nm);
  endtask

  // the decode port must see pc, pc+4, ... from each reset or redirect target
  task automatic topup();
    while (q.size() < 8) begin
      q.push_back('{gen_pc, mem_word(gen_pc)});
      gen_pc += 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    q.delete();
    gen_pc = pc & ~32'h3;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic do_reset();
    rst = 0;
    redirect = 0;
    restart(RESET_PC);
    tick();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    tick();
    rst = 1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input string nm);
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == a) break;
      tick();
    end
    if (!(imem_req && imem_addr == a)) to_fail(nm);
  endtask

  task automatic async_reset_check(input string nm);
    #2;
    rst = 0;
    redirect = 0;
    restart(RESET_PC);
    #1;
    chk({nm, "_req"}, 32'(imem_req), 0);
    chk({nm, "_valid"}, 32'(inst_valid), 0);
    chk({nm, "_inst"}, inst, 0);
    chk({nm, "_pc"}, inst_pc, 0);
    repeat (2) tick();
    rst = 1;
    slow_addr = 32'hFFFF_FFFF;
    tick();
    chk({nm, "_first_req"}, 32'(imem_req), 1);
    chk({nm, "_first_addr"}, imem_addr, RESET_PC);
  endtask

  // instruction memory: random or per-address fixed latency
  initial forever begin
    @(negedge clk);
    if (!rst || !imem_req) begin
      imem_ack = 0;
      wait_cnt = 0;
    end else begin
      imem_ack = (imem_addr == slow_addr) ? (wait_cnt >= slow_lat)
                                          : (int'($urandom_range(0, 99)) < ack_pct);
      wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
  end

  // monitor: protocol rules and in-order stream scoreboard
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      p_req = 0; p_ack = 0; p_val = 0; p_rdy = 0; p_redir = 0;
    end else begin
      if (p_redir) chk("valid_after_redirect", 32'(inst_valid), 0);
      if (p_req && !p_ack) begin
        chk("req_held", 32'(imem_req), 1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (p_val && !p_rdy && !p_redir) begin
        chk("head_valid_held", 32'(inst_valid), 1);
        chk("head_inst_held", inst, p_inst);
        chk("head_pc_held", inst_pc, p_pc);
      end
      if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 0);
      if (inst_valid && inst_ready && !redirect) begin
        if (q.size() == 0) to_fail("stream_empty");
        else begin
          e = q.pop_front();
          chk("stream_pc", inst_pc, e.pc);
          chk("stream_inst", inst, e.w);
          n_acc++;
        end
      end
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_val = inst_valid; p_rdy = inst_ready; p_redir = redirect;
      p_inst = inst; p_pc = inst_pc;
    end
  end

  initial begin
    #1;
    // zero-wait memory, always-ready decode
    ack_pct = 100;
    inst_ready = 1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_req", 32'(imem_req), 1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        chk("t1_valid", 32'(inst_valid), 1);
        chk("t1_inst_pc", inst_pc, 32'(4 * (k - 1)));
        chk("t1_inst", inst, mem_word(32'(4 * (k - 1))));
      end
    end
    tick();
    chk("t1_inst_pc_c", inst_pc, 32'hC);
    // decode stalled: fetch stops at DEPTH buffered words
    inst_ready = 0;
    do_reset();
    tick();
    chk("t2_addr0", imem_addr, 32'h0);
    tick();
    chk("t2_addr4", imem_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_req_low", 32'(imem_req), 0);
    end
    chk("t2_head0_valid", 32'(inst_valid), 1);
    chk("t2_head0", inst_pc, 32'h0);
    inst_ready = 1;
    tick();
    chk("t2_head4", inst_pc, 32'h4);
    tick();
    chk("t2_head8_valid", 32'(inst_valid), 1);
    chk("t2_head8", inst_pc, 32'h8);
    // redirect during a slow request at 0x8
    slow_addr = 32'h8;
    slow_lat = 3;
    do_reset();
    wait_addr(32'h8, "t3_wait_addr8");
    tick();
    redirect = 1;
    redirect_pc = 32'h40;
    restart(32'h40);
    tick();
    redirect = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(imem_req && imem_addr == 32'h8)) break;
      tick();
    end
    chk("t3_next_addr", imem_addr, 32'h40);
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      tick();
    end
    chk("t3_first_valid", 32'(inst_valid), 1);
    chk("t3_first_pc", inst_pc, 32'h40);
    slow_addr = 32'hFFFF_FFFF;
    // redirect coinciding with the ack for 0xC
    do_reset();
    wait_addr(32'hC, "t4_wait_addrC");
    redirect = 1;
    redirect_pc = 32'h43;
    restart(32'h43);
    tick();
    redirect = 0;
    chk("t4_valid_low", 32'(inst_valid), 0);
    chk("t4_addr", imem_addr, 32'h40);
    tick();
    chk("t4_first_pc", inst_pc, 32'h40);
    // fetch pc wraps at the top of the address space
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFC;
    restart(32'hFFFF_FFFC);
    tick();
    redirect = 0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_wrap", imem_addr, 32'h0);
    chk("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc_wrap", inst_pc, 32'h0);
    // async reset while a dropped request is outstanding
    slow_addr = 32'h8;
    slow_lat = 1000;
    do_reset();
    wait_addr(32'h8, "t6_wait_addr8");
    tick();
    redirect = 1;
    redirect_pc = 32'h100;
    restart(32'h100);
    tick();
    redirect = 0;
    chk("t6_drop_addr", imem_addr, 32'h8);
    async_reset_check("t6");
    // randomized interleaving of ack latency, ready and redirects
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ack_pct = int'($urandom_range(20, 100));
      inst_ready = ($urandom_range(0, 99) < 60);
      if (!redirect && $urandom_range(0, 24) == 0) begin
        redirect = 1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                   : $urandom;
        restart(redirect_pc);
      end else redirect = 0;
      tick();
    end
    redirect = 0;
    inst_ready = 0;
    for (int i = 0; i < 50; i++) begin
      if (inst_valid) break;
      tick();
    end
    chk("end_valid_before_reset", 32'(inst_valid), 1);
    async_reset_check("end");
    chk("progress", 32'(n_acc > 300), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
